// File: rtl/aes_bus_master.sv
// aes_bus_master: memory-side initiator for the AES accelerator buses.
// Accepts one command at a time, drives the transaction encoding, streams
// key/text bytes from memory, buffers result bytes in a small skid FIFO and
// closes result transfers with the ack handshake.
module aes_bus_master #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] AES_ID     = 2'b10,
  parameter logic [1:0] MEM_ID     = 2'b00
) (
  input  logic        clk,
  input  logic        rst_n,
  // command interface
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic        cmd_encdec,
  input  logic [23:0] cmd_addr,
  // memory byte source
  input  logic [7:0]  src_data,
  input  logic        src_valid,
  output logic        src_ready,
  // memory result sink
  output logic [7:0]  res_data,
  output logic        res_valid,
  input  logic        res_ready,
  // transaction encoding
  output logic [1:0]  opcode,
  output logic [1:0]  source_id,
  output logic [1:0]  dest_id,
  output logic        encdec,
  output logic [23:0] addr,
  // accelerator data bus
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  // accelerator ack bus
  input  logic        ack_valid,
  output logic        ack_ready,
  input  logic [1:0]  ack_source_id,
  // status
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_RESULT,
    ST_ACK
  } state_t;

  state_t      state_q;
  logic [1:0]  opcode_q;
  logic [1:0]  source_id_q;
  logic [1:0]  dest_id_q;
  logic        encdec_q;
  logic [23:0] addr_q;
  logic [5:0]  cnt_q;      // load beats, or result bytes received
  logic [5:0]  target_q;   // number of load beats for the active command
  logic [4:0]  req_q;      // result bytes requested so far
  logic        pending_q;  // a request went out last cycle; its byte arrives now
  logic        done_q;
  logic        err_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] fcount_q;
  logic [CW-1:0] fcount_d;

  logic          fifo_empty;
  logic          fifo_full;
  logic [CW:0]   occupancy;
  logic          rx_window;
  logic          rx_push;
  logic          rx_drop;
  logic          fifo_pop;
  logic          beat;

  assign fifo_empty = (fcount_q == '0);
  assign fifo_full  = (fcount_q == CW'(FIFO_DEPTH));
  // Entries already stored plus the byte still in flight from last request.
  assign occupancy  = {1'b0, fcount_q} + {{CW{1'b0}}, pending_q};
  assign rx_window  = pending_q || (state_q == ST_RESULT);
  assign rx_push    = rx_valid && rx_window && !fifo_full;
  assign rx_drop    = rx_valid && (!rx_window || fifo_full);
  assign fifo_pop   = !fifo_empty && res_ready;

  // Load data passes straight through so a beat costs no extra cycle.
  assign tx_valid  = (state_q == ST_LOAD) && src_valid;
  assign tx_data   = (state_q == ST_LOAD) ? src_data : 8'h00;
  assign src_ready = (state_q == ST_LOAD) && tx_ready;
  assign beat      = tx_valid && tx_ready;

  // Only request when the reply (one cycle later) is guaranteed a slot.
  assign rx_ready  = (state_q == ST_RESULT) && !req_q[4] &&
                     (occupancy < (CW+1)'(FIFO_DEPTH));
  assign ack_ready = (state_q == ST_ACK);

  assign cmd_ready = (state_q == ST_IDLE) && fifo_empty;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign opcode    = opcode_q;
  assign source_id = source_id_q;
  assign dest_id   = dest_id_q;
  assign encdec    = encdec_q;
  assign addr      = addr_q;

  assign res_valid = !fifo_empty;
  assign res_data  = mem_q[rd_ptr_q];

  // Command FSM with registered encoding, done pulse and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      opcode_q    <= 2'b00;
      source_id_q <= MEM_ID;
      dest_id_q   <= MEM_ID;
      encdec_q    <= 1'b0;
      addr_q      <= 24'h0;
      cnt_q       <= 6'd0;
      target_q    <= 6'd0;
      req_q       <= 5'd0;
      pending_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      pending_q <= rx_ready;
      if (rx_drop) err_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            encdec_q <= cmd_encdec;
            addr_q   <= cmd_addr;
            cnt_q    <= 6'd0;
            req_q    <= 5'd0;
            case (cmd_op)
              2'b00: begin
                state_q     <= ST_LOAD;
                target_q    <= 6'd32;
                opcode_q    <= 2'b00;
                source_id_q <= MEM_ID;
                dest_id_q   <= AES_ID;
              end
              2'b01: begin
                state_q     <= ST_LOAD;
                target_q    <= 6'd16;
                opcode_q    <= 2'b01;
                source_id_q <= MEM_ID;
                dest_id_q   <= AES_ID;
              end
              2'b11: begin
                state_q     <= ST_START;
                opcode_q    <= 2'b11;
                source_id_q <= MEM_ID;
                dest_id_q   <= AES_ID;
              end
              default: begin
                state_q     <= ST_RESULT;
                opcode_q    <= 2'b10;
                source_id_q <= AES_ID;
                dest_id_q   <= MEM_ID;
              end
            endcase
          end
        end
        ST_LOAD: begin
          if (beat) begin
            if (cnt_q == target_q - 6'd1) begin
              state_q     <= ST_IDLE;
              opcode_q    <= 2'b00;
              source_id_q <= MEM_ID;
              dest_id_q   <= MEM_ID;
              cnt_q       <= 6'd0;
              done_q      <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
        end
        ST_START: begin
          state_q     <= ST_IDLE;
          opcode_q    <= 2'b00;
          source_id_q <= MEM_ID;
          dest_id_q   <= MEM_ID;
          done_q      <= 1'b1;
        end
        ST_RESULT: begin
          if (rx_ready) req_q <= req_q + 5'd1;
          if (rx_push) begin
            if (cnt_q == 6'd15) begin
              state_q <= ST_ACK;
              cnt_q   <= 6'd0;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
        end
        ST_ACK: begin
          if (ack_valid) begin
            if (ack_source_id != AES_ID) err_q <= 1'b1;
            state_q     <= ST_IDLE;
            opcode_q    <= 2'b00;
            source_id_q <= MEM_ID;
            dest_id_q   <= MEM_ID;
            done_q      <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // FIFO occupancy: simultaneous push and pop leave it unchanged.
  always_comb begin
    fcount_d = fcount_q;
    case ({rx_push, fifo_pop})
      2'b10:   fcount_d = fcount_q + CW'(1);
      2'b01:   fcount_d = fcount_q - CW'(1);
      default: fcount_d = fcount_q;
    endcase
  end

  // FIFO pointers and count; reset discards contents by emptying it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcount_q <= '0;
    end else begin
      if (rx_push)  wr_ptr_q <= wr_ptr_q + PW'(1);
      if (fifo_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      fcount_q <= fcount_d;
    end
  end

  // FIFO storage; no reset needed since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (rx_push) mem_q[wr_ptr_q] <= rx_data;
  end

endmodule
